// File: rtl/lcd_fetch_pkg.sv
// Shared types, defaults and width helpers for the LCD frame fetch scheduler.
// Imported by the scheduler top and its response buffer.
package lcd_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   localparam int DATA_W_DEF     = 64;
   localparam int ADDR_W_DEF     = 32;
   localparam int CNT_W_DEF      = 20;
   localparam int BURST_LEN_DEF  = 8;
   localparam int RESP_DEPTH_DEF = 32;

   // Counter width able to hold 0..n inclusive for power-of-2 n.
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic logic [31:0] min_burst(
      input logic [31:0] rem,
      input logic [31:0] blen
   );
      return (rem < blen) ? rem : blen;
   endfunction

endpackage

// File: rtl/lcd_fetch_resp_buf.sv
// Show-ahead single-clock response buffer with occupancy count.
// Absorbs read data that cannot be backpressured.
module lcd_fetch_resp_buf
   import lcd_fetch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = RESP_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       inc;
   logic [AW:0]       dec;

   assign rd_data = mem[rd_ptr];
   assign empty   = (count == '0);
   assign inc     = (AW+1)'(wr);
   assign dec     = (AW+1)'(rd);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + inc - dec;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(wr && count == (AW+1)'(DEPTH)))
            else $error("resp_buf write when full");
         assert (!(rd && empty))
            else $error("resp_buf read when empty");
      end
   end

endmodule

// File: rtl/lcd_frame_fetch_scheduler.sv
// Splits a frame into credit-gated Avalon-MM read bursts and streams the
// returned words out as one Avalon-ST packet per frame.
module lcd_frame_fetch_scheduler
   import lcd_fetch_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int BURST_LEN  = BURST_LEN_DEF,
   parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ADDR_W-1:0]             cfg_base,
   input  logic [CNT_W-1:0]              cfg_words,
   input  logic                          cfg_continuous,
   input  logic                          go,
   input  logic                          stop,
   output logic                          busy,
   output logic                          frame_done,
   output logic [ADDR_W-1:0]             avm_address,
   output logic                          avm_read,
   output logic [$clog2(BURST_LEN):0]    avm_burstcount,
   input  logic                          avm_waitrequest,
   input  logic [DATA_W-1:0]             avm_readdata,
   input  logic                          avm_readdatavalid,
   output logic [DATA_W-1:0]             src_data,
   output logic                          src_valid,
   output logic                          src_startofpacket,
   output logic                          src_endofpacket,
   output logic [2:0]                    src_empty,
   input  logic                          src_ready
);

   localparam int BC_W = cnt_w(BURST_LEN);
   localparam int OC_W = cnt_w(RESP_DEPTH);
   localparam int BSH  = $clog2(DATA_W/8);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  words_q;
   logic              cont_q;
   logic [CNT_W-1:0]  rem_issue;
   logic [CNT_W-1:0]  out_cnt;
   logic [OC_W-1:0]   outstanding;
   logic [OC_W-1:0]   buf_count;
   logic [OC_W-1:0]   out_inc;
   logic [OC_W-1:0]   out_dec;
   logic [BC_W-1:0]   burst;
   logic [OC_W:0]     credit;
   logic [DATA_W-1:0] head;
   logic              buf_empty;
   logic              start;
   logic              accept;
   logic              last_acc;
   logic              rdv_take;
   logic              pop;
   logic              last_word;
   logic              restart;

   assign start     = (state == IDLE) && go && (cfg_words != '0);
   assign accept    = avm_read && !avm_waitrequest;
   assign last_acc  = accept && (rem_issue == CNT_W'(avm_burstcount));
   // Data after a reset has no outstanding request to match and is dropped.
   assign rdv_take  = avm_readdatavalid && (outstanding != '0);
   assign burst     = BC_W'(min_burst(32'(rem_issue), 32'(BURST_LEN)));
   assign credit    = (OC_W+1)'(RESP_DEPTH)
                    - {1'b0, buf_count} - {1'b0, outstanding};

   assign src_valid         = !buf_empty;
   assign src_data          = src_valid ? head : '0;
   assign src_empty         = 3'b000;
   assign pop               = src_valid && src_ready;
   assign last_word         = (out_cnt == words_q - 1'b1);
   assign src_startofpacket = src_valid && (out_cnt == '0);
   assign src_endofpacket   = src_valid && last_word;
   assign frame_done        = (state == DRAIN) && pop && last_word;
   assign restart           = frame_done && cont_q && !stop;
   assign busy              = (state != IDLE);

   assign out_inc = accept ? OC_W'(avm_burstcount) : '0;
   assign out_dec = OC_W'(rdv_take);

   lcd_fetch_resp_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (RESP_DEPTH)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr      (rdv_take),
      .wr_data (avm_readdata),
      .rd      (pop),
      .rd_data (head),
      .count   (buf_count),
      .empty   (buf_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   if (last_acc) state_nxt = DRAIN;
         DRAIN:   if (frame_done) state_nxt = restart ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q         <= '0;
         words_q        <= '0;
         cont_q         <= 1'b0;
         rem_issue      <= '0;
         out_cnt        <= '0;
         outstanding    <= '0;
         avm_address    <= '0;
         avm_read       <= 1'b0;
         avm_burstcount <= '0;
      end else begin
         if (start) begin
            base_q      <= cfg_base;
            words_q     <= cfg_words;
            cont_q      <= cfg_continuous;
            avm_address <= cfg_base;
            rem_issue   <= cfg_words;
            out_cnt     <= '0;
         end else if (stop) begin
            cont_q <= 1'b0;
         end
         if (restart) begin
            avm_address <= base_q;
            rem_issue   <= words_q;
         end
         // A bubble after each acceptance lets credit see the new outstanding.
         if (accept) begin
            avm_read    <= 1'b0;
            avm_address <= avm_address + (ADDR_W'(avm_burstcount) << BSH);
            rem_issue   <= rem_issue - CNT_W'(avm_burstcount);
         end else if (state == ISSUE && !avm_read && rem_issue != '0
                      && credit >= (OC_W+1)'(burst)) begin
            avm_read       <= 1'b1;
            avm_burstcount <= burst;
         end
         outstanding <= outstanding + out_inc - out_dec;
         if (pop) out_cnt <= last_word ? '0 : out_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert ({1'b0, buf_count} + {1'b0, outstanding}
                 <= (OC_W+1)'(RESP_DEPTH))
            else $error("response credit overcommitted");
      end
   end

endmodule

// File: doc/lcd_frame_fetch_scheduler.md
Name: lcd_frame_fetch_scheduler

Overview:
Frame-level read scheduler that feeds the LCD pixel FIFO sink. It splits one frame (base address and word count) into Avalon-MM read bursts to the frame buffer. Bursts are issued only when a local response buffer can absorb the whole burst, because readdatavalid cannot be backpressured. Buffered words go out as an Avalon-ST packet, one packet per frame with SOP/EOP, into the pixel FIFO write side. Runs single-shot or continuously, frame after frame.

Parameters:
DATA_W, 64, pixel word width (matches FIFO sink data)
ADDR_W, 32, byte address width
CNT_W, 20, frame word-count width
BURST_LEN, 8, maximum burst in words (power of 2)
RESP_DEPTH, 32, response buffer depth in words (power of 2, >= 2*BURST_LEN)

Ports:
clk  in  1  single clock, same as pixel FIFO write clock
reset  in  1  synchronous active-high reset
cfg_base  in  ADDR_W  frame start byte address, DATA_W/8 aligned
cfg_words  in  CNT_W  words per frame
cfg_continuous  in  1  restart automatically at end of frame
go  in  1  start pulse, honoured in IDLE only
stop  in  1  pulse: clear continuous latch; current frame completes
busy  out  1  high outside IDLE
frame_done  out  1  one-cycle pulse when EOP word is accepted downstream
avm_address  out  ADDR_W  burst start byte address
avm_read  out  1  read request
avm_burstcount  out  log2(BURST_LEN)+1  words in burst
avm_waitrequest  in  1  slave stall
avm_readdata  in  DATA_W  returned word
avm_readdatavalid  in  1  returned word valid
src_data  out  DATA_W  to FIFO avalonst_sink_data
src_valid  out  1  to FIFO avalonst_sink_valid
src_startofpacket  out  1  first word of frame
src_endofpacket  out  1  last word of frame
src_empty  out  3  constant 0 (full words only)
src_ready  in  1  from FIFO avalonst_sink_ready

Behaviour:
- Reset values: every output 0; state IDLE; counters, continuous latch and buffer cleared. Reset mid-burst: avm_read goes low on the first cycle after reset. Late readdatavalid returning after reset is ignored; the system resets slaves together.
- States: IDLE, ISSUE, DRAIN.
- IDLE: go with cfg_words != 0 latches base, words and continuous, then moves to ISSUE next cycle. go with cfg_words == 0 is ignored.
- ISSUE:
  - burst = min(BURST_LEN, rem_issue).
  - credit = RESP_DEPTH - buf_count - outstanding.
  - Assert avm_read when credit >= burst.
  - address and burstcount held stable while avm_waitrequest = 1.
  - On acceptance (avm_read & !avm_waitrequest): address += burst*DATA_W/8; rem_issue -= burst; outstanding += burst.
  - Next cycle after the acceptance that zeroes rem_issue, avm_read deasserts and state moves to DRAIN.
  - No new request in the acceptance cycle's next cycle unless credit is recomputed with the new outstanding (no back-to-back overcommit).
- Readdatavalid: write word into buffer; outstanding -= 1. Simultaneous accept and return: outstanding += burst - 1.
- Buffer invariant: buf_count + outstanding <= RESP_DEPTH always. Buffer overflow is impossible and is asserted in simulation.
- Output:
  - src_valid = buffer not empty (show-ahead); pop on src_valid & src_ready. Zero-latency ready, ready latency 0.
  - src_data held stable while src_valid & !src_ready.
  - out_cnt counts accepted words.
  - SOP when out_cnt == 0; EOP when out_cnt == words-1. A single-word frame has SOP = EOP = 1.
- DRAIN: leave when the EOP word is accepted; frame_done pulses that cycle.
  - Continuous latch set: reload base and words, out_cnt = 0, go to ISSUE.
  - Otherwise go to IDLE.
- stop: clears the continuous latch in any state, including the same cycle as EOP, which then ends in IDLE. stop in IDLE has no effect.
- go while busy: ignored.
- Counter widths: rem_issue and out_cnt are CNT_W; outstanding and buf_count are log2(RESP_DEPTH)+1. Address wraps modulo 2^ADDR_W.

Decomposition:
- Package lcd_fetch_pkg:
  - state enum {IDLE, ISSUE, DRAIN}
  - BURST_LEN, RESP_DEPTH defaults
  - function min_burst
  - width derivation constants
- Sub-module lcd_fetch_resp_buf: single-clock show-ahead FIFO, RESP_DEPTH x DATA_W, with count output.
  - Write-when-full and read-when-empty trigger simulation assertions.

Test Plan:
- Base 0x1000, words 20, waitrequest 0, src_ready 1 → bursts (0x1000,8), (0x1040,8), (0x1080,4); 20 words out; SOP on word 0, EOP on word 19; one frame_done; IDLE.
- src_ready held 0, words 64 → exactly 4 bursts (32 words) issued, then avm_read stays 0. Raising src_ready resumes issue; no data lost; outstanding + buf_count never exceeds 32.
- waitrequest high 5 cycles on the first burst → avm_address and avm_burstcount stable all 5 cycles; one acceptance recorded.
- words 1 → burstcount 1; single output word with SOP = EOP = 1; frame_done.
- cfg_continuous 1, words 16 → frame 2 restarts at cfg_base. Pulse stop mid-frame 2 → frame 2 completes with EOP, then IDLE; busy falls the cycle after frame_done.
- Reset asserted while avm_read = 1 and 3 words are buffered → next cycle all outputs 0 and IDLE. A following go, words 8, produces a clean packet with SOP and EOP correct.
